// File: rtl/iram_loader.sv
// Boot loader: parses a framed byte stream into 32-bit words for the instruction RAM.
// The core is held in reset until a frame with a good checksum has loaded.
module iram_loader #(
    parameter int          DEPTH       = 1024,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        iram_we,
    output logic [31:0] iram_waddr,
    output logic [31:0] iram_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);
    localparam int AW = $clog2(DEPTH) + 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, ERR} state_t;
    state_t state, state_nxt;

    logic          accept;
    logic          timed;
    logic          tmo;
    logic          word_done;
    logic          last_word;
    logic [7:0]    len_lo;
    logic [AW-1:0] len_q;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic [23:0]   shreg;
    logic [7:0]    csum;
    logic [TW-1:0] tcnt;

    assign s_ready   = 1'b1;
    assign accept    = s_valid;
    assign timed     = state inside {LEN0, LEN1, DATA, CSUM};
    // A byte arriving on the terminal count wins, so tmo requires no accept.
    assign tmo       = (TIMEOUT_CYC != 0) && timed && !accept && (tcnt == T_LAST);
    assign word_done = (state == DATA) && accept && (lane == 2'd3);
    assign last_word = (widx == len_q - AW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tmo) begin
            state_nxt = ERR;
        end else begin
            case (state)
                IDLE: if (accept && s_data == SYNC_BYTE) state_nxt = LEN0;
                LEN0: if (accept) state_nxt = LEN1;
                LEN1: if (accept) begin
                    if ({1'b0, s_data, len_lo} > 17'(DEPTH)) state_nxt = ERR;
                    else if ({s_data, len_lo} == 16'd0)     state_nxt = CSUM;
                    else                                     state_nxt = DATA;
                end
                DATA: if (word_done && last_word) state_nxt = CSUM;
                CSUM: if (accept) state_nxt = (s_data == csum) ? IDLE : ERR;
                ERR:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iram_we    <= 1'b0;
            iram_waddr <= '0;
            iram_wdata <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            len_lo     <= '0;
            len_q      <= '0;
            widx       <= '0;
            lane       <= '0;
            shreg      <= '0;
            csum       <= '0;
            tcnt       <= '0;
        end else begin
            iram_we <= 1'b0;
            if (!timed || accept)        tcnt <= '0;
            else if (TIMEOUT_CYC != 0)   tcnt <= tcnt + TW'(1);

            case (state)
                IDLE: if (accept && s_data == SYNC_BYTE) begin
                    cpu_hold  <= 1'b1;
                    load_done <= 1'b0;
                    load_err  <= 1'b0;
                    csum      <= '0;
                    widx      <= '0;
                    lane      <= '0;
                end
                LEN0: if (accept) len_lo <= s_data;
                LEN1: if (accept) len_q <= AW'({s_data, len_lo});
                DATA: if (accept) begin
                    csum <= csum + s_data;
                    lane <= lane + 2'd1;
                    if (lane == 2'd3) begin
                        iram_we    <= 1'b1;
                        iram_waddr <= 32'(widx);
                        iram_wdata <= {s_data, shreg};
                        widx       <= widx + AW'(1);
                    end else begin
                        shreg <= {s_data, shreg[23:8]};
                    end
                end
                CSUM: if (accept && s_data == csum) begin
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
                end
                ERR: load_err <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: expected IRAM writes go to a scoreboard queue
// that a negedge monitor drains; status flags are checked after each frame.
module tb_iram_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        iram_we;
    logic [31:0] iram_waddr;
    logic [31:0] iram_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    iram_loader #(
        .DEPTH      (1024),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .iram_we   (iram_we),
        .iram_waddr(iram_waddr),
        .iram_wdata(iram_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          total  = 0;
    int          bad    = 0;
    int          wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (iram_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=%h:%h required=none", iram_waddr, iram_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("waddr", iram_waddr, e.a);
                check("wdata", iram_wdata, e.d);
            end
        end
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; byte is accepted on the following posedge.
    task automatic send(input logic [7:0] b, input int gap);
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    function automatic logic [7:0] img_csum();
        logic [7:0] s = 8'h00;
        foreach (img[i]) begin
            logic [31:0] w = img[i];
            s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
        end
        return s;
    endfunction

    // ndata < 0 sends every data byte plus the checksum; otherwise stops after ndata bytes.
    task automatic send_frame(input logic [15:0] len, input logic [7:0] cs, input int gap, input int ndata);
        int sent = 0;
        send(8'hA5, gap);
        send(len[7:0], gap);
        send(len[15:8], gap);
        for (int w = 0; w < img.size(); w++) begin
            logic [31:0] wv = img[w];
            for (int b = 0; b < 4; b++) begin
                if (ndata >= 0 && sent == ndata) return;
                if (b == 3) exp_q.push_back({32'(w), wv});
                send(wv[8*b +: 8], gap);
                sent++;
            end
        end
        if (ndata < 0) send(cs, gap);
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err, input logic hold);
        check({tag, "_load_done"}, 32'(load_done), 32'(done));
        check({tag, "_load_err"},  32'(load_err),  32'(err));
        check({tag, "_cpu_hold"},  32'(cpu_hold),  32'(hold));
    endtask

    initial begin
        int w0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_iram_we", 32'(iram_we), 32'd0);
        check("rst_waddr", iram_waddr, 32'd0);
        check("rst_wdata", iram_wdata, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two-word frame, good checksum
        img = '{32'h0000_0013, 32'h0000_006F};
        w0 = wr_cnt;
        send_frame(16'd2, 8'h82, 0, -1);
        repeat (3) @(negedge clk);
        check("t1_writes", 32'(wr_cnt - w0), 32'd2);
        check_flags("t1", 1'b1, 1'b0, 1'b0);

        // Same frame, bad checksum: writes still happen
        w0 = wr_cnt;
        send_frame(16'd2, 8'h81, 0, -1);
        repeat (3) @(negedge clk);
        check("t2_writes", 32'(wr_cnt - w0), 32'd2);
        check_flags("t2", 1'b0, 1'b1, 1'b1);

        // Garbage before sync, empty image
        img = {};
        w0 = wr_cnt;
        send(8'h00, 0);
        send(8'hFF, 0);
        send(8'h12, 0);
        send_frame(16'd0, 8'h00, 0, -1);
        repeat (3) @(negedge clk);
        check("t3_writes", 32'(wr_cnt - w0), 32'd0);
        check_flags("t3", 1'b1, 1'b0, 1'b0);

        // Oversized length rejected right after LEN_HI
        w0 = wr_cnt;
        send_frame(16'h0401, 8'h00, 0, 0);
        repeat (3) @(negedge clk);
        check("t4_writes", 32'(wr_cnt - w0), 32'd0);
        check_flags("t4", 1'b0, 1'b1, 1'b1);

        // Timeout after two data bytes: partial word discarded
        img = '{32'hDEAD_BEEF};
        w0 = wr_cnt;
        send_frame(16'd1, 8'h00, 0, 2);
        repeat (60) @(negedge clk);
        check("t5_writes", 32'(wr_cnt - w0), 32'd0);
        check_flags("t5", 1'b0, 1'b1, 1'b1);

        // 49 idle cycles between bytes stays just inside the timeout
        img = '{32'h1234_5678};
        w0 = wr_cnt;
        send_frame(16'd1, 8'h14, 49, -1);
        repeat (3) @(negedge clk);
        check("t6_writes", 32'(wr_cnt - w0), 32'd1);
        check_flags("t6", 1'b1, 1'b0, 1'b0);

        // Full-depth image, throttled, aborted by reset mid-frame
        img = {};
        for (int i = 0; i < 1024; i++) img.push_back(32'h1000_0000 + 32'(i) * 32'h0001_0003);
        send_frame(16'd1024, 8'h00, 2, 500 * 4 + 2);
        repeat (2) @(negedge clk);
        check("t7_pre_waddr", iram_waddr, 32'd499);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_iram_we", 32'(iram_we), 32'd0);
        check("t7_rst_waddr", iram_waddr, 32'd0);
        check("t7_rst_wdata", iram_wdata, 32'd0);
        check_flags("t7_rst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        w0 = wr_cnt;
        send_frame(16'd1024, img_csum(), 2, -1);
        repeat (3) @(negedge clk);
        check("t8_writes", 32'(wr_cnt - w0), 32'd1024);
        check_flags("t8", 1'b1, 1'b0, 1'b0);
        check("t8_last_waddr", iram_waddr, 32'd1023);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
